// File: rtl/comparator_pkg.sv
// Shared types for the pipelined magnitude comparator: compare outcome encoding
// and its expansion to the {gt,lt,eq} flag triple.
package comparator_pkg;

  typedef enum logic [1:0] {
    CMP_EQ = 2'd0,
    CMP_LT = 2'd1,
    CMP_GT = 2'd2
  } cmp_res_e;

  function automatic logic [2:0] to_onehot(input cmp_res_e res);
    logic [2:0] oh;
    case (res)
      CMP_GT:  oh = 3'b100;
      CMP_LT:  oh = 3'b010;
      default: oh = 3'b001;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/comparator_core.sv
// Combinational compare of two operands, unsigned or two's-complement, giving the
// outcome and the absolute difference.
module comparator_core
  import comparator_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output cmp_res_e         res,
  output logic [WIDTH-1:0] diff
);

  logic [WIDTH:0] a_ext;
  logic [WIDTH:0] b_ext;
  logic [WIDTH:0] d;

  // One extra bit makes a-b exact for both modes, so its sign bit is the ordering.
  assign a_ext = {signed_mode & a[WIDTH-1], a};
  assign b_ext = {signed_mode & b[WIDTH-1], b};
  assign d     = a_ext - b_ext;

  always_comb begin
    if (d == '0) begin
      res = CMP_EQ;
    end else if (d[WIDTH]) begin
      res = CMP_LT;
    end else begin
      res = CMP_GT;
    end
  end

  assign diff = d[WIDTH] ? WIDTH'(-d) : WIDTH'(d);

endmodule

// File: rtl/comparator_pipe_nbit.sv
// Two-stage valid/ready comparator pipeline (S1 operands, S2 result) with
// saturating per-outcome delivery counters.
module comparator_pipe_nbit
  import comparator_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             a_gt_b,
  output logic             a_lt_b,
  output logic             a_eq_b,
  output logic [WIDTH-1:0] diff,
  input  logic             clr_counts,
  output logic [CNT_W-1:0] gt_count,
  output logic [CNT_W-1:0] lt_count,
  output logic [CNT_W-1:0] eq_count
);

  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_a_q;
  logic [WIDTH-1:0] s1_b_q;
  logic             s1_sm_q;

  logic             out_valid_q;
  logic             gt_q, lt_q, eq_q;
  logic [WIDTH-1:0] diff_q;

  logic [CNT_W-1:0] gt_cnt_q, gt_cnt_d;
  logic [CNT_W-1:0] lt_cnt_q, lt_cnt_d;
  logic [CNT_W-1:0] eq_cnt_q, eq_cnt_d;

  logic             s2_free;
  logic             in_hs;
  logic             out_hs;
  cmp_res_e         core_res;
  logic [WIDTH-1:0] core_diff;
  logic [2:0]       core_oh;

  assign s2_free  = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_free;
  assign in_hs    = in_valid && in_ready;
  assign out_hs   = out_valid_q && out_ready;

  comparator_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .a          (s1_a_q),
    .b          (s1_b_q),
    .signed_mode(s1_sm_q),
    .res        (core_res),
    .diff       (core_diff)
  );

  assign core_oh = to_onehot(core_res);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_sm_q    <= 1'b0;
    end else if (in_ready) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_a_q  <= a;
        s1_b_q  <= b;
        s1_sm_q <= signed_mode;
      end
    end
  end

  // Result registers only load on a real transfer, so flags/diff persist while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      gt_q        <= 1'b0;
      lt_q        <= 1'b0;
      eq_q        <= 1'b0;
      diff_q      <= '0;
    end else if (s2_free) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        {gt_q, lt_q, eq_q} <= core_oh;
        diff_q             <= core_diff;
      end
    end
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  always_comb begin
    gt_cnt_d = gt_cnt_q;
    lt_cnt_d = lt_cnt_q;
    eq_cnt_d = eq_cnt_q;
    if (clr_counts) begin
      gt_cnt_d = '0;
      lt_cnt_d = '0;
      eq_cnt_d = '0;
    end else if (out_hs) begin
      if (gt_q) gt_cnt_d = sat_inc(gt_cnt_q);
      if (lt_q) lt_cnt_d = sat_inc(lt_cnt_q);
      if (eq_q) eq_cnt_d = sat_inc(eq_cnt_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gt_cnt_q <= '0;
      lt_cnt_q <= '0;
      eq_cnt_q <= '0;
    end else begin
      gt_cnt_q <= gt_cnt_d;
      lt_cnt_q <= lt_cnt_d;
      eq_cnt_q <= eq_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign a_gt_b    = gt_q;
  assign a_lt_b    = lt_q;
  assign a_eq_b    = eq_q;
  assign diff      = diff_q;
  assign gt_count  = gt_cnt_q;
  assign lt_count  = lt_cnt_q;
  assign eq_count  = eq_cnt_q;

endmodule

// File: tb/tb_comparator_pipe_nbit.sv
// Scoreboard bench for comparator_pipe_nbit (WIDTH=8, CNT_W=4 so saturation is reachable).
module tb_comparator_pipe_nbit;

  localparam int W       = 8;
  localparam int CW      = 4;
  localparam int CNT_MAX = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready;
  logic [W-1:0]  a, b;
  logic          signed_mode;
  logic          out_valid, out_ready;
  logic          a_gt_b, a_lt_b, a_eq_b;
  logic [W-1:0]  diff;
  logic          clr_counts;
  logic [CW-1:0] gt_count, lt_count, eq_count;

  typedef struct {
    logic [2:0]   fl;
    logic [W-1:0] df;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_gt = 0, exp_lt = 0, exp_eq = 0;
  bit   stall_q = 0;
  logic [3:0]   held_fl;
  logic [W-1:0] held_df;

  always #5 clk = ~clk;

  comparator_pipe_nbit #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .signed_mode(signed_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .a_gt_b     (a_gt_b),
    .a_lt_b     (a_lt_b),
    .a_eq_b     (a_eq_b),
    .diff       (diff),
    .clr_counts (clr_counts),
    .gt_count   (gt_count),
    .lt_count   (lt_count),
    .eq_count   (eq_count)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic sm);
    int   xv, yv, d;
    exp_t e;
    xv   = (sm && x[W-1]) ? int'(x) - 256 : int'(x);
    yv   = (sm && y[W-1]) ? int'(y) - 256 : int'(y);
    d    = xv - yv;
    e.fl = {d > 0, d < 0, d == 0};
    e.df = W'(d < 0 ? -d : d);
    return e;
  endfunction

  function automatic int sat(input int c);
    return (c >= CNT_MAX) ? CNT_MAX : c + 1;
  endfunction

  // Monitor: samples at negedge, mid-cycle between drive (posedge+1) and capture.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb.delete();
      exp_gt  = 0;
      exp_lt  = 0;
      exp_eq  = 0;
      stall_q = 0;
    end else begin
      check("gt_count", 32'(gt_count), exp_gt);
      check("lt_count", 32'(lt_count), exp_lt);
      check("eq_count", 32'(eq_count), exp_eq);
      if (stall_q) begin
        check("hold_flags", {28'd0, out_valid, a_gt_b, a_lt_b, a_eq_b}, {28'd0, held_fl});
        check("hold_diff", 32'(diff), 32'(held_df));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_out", 32'(out_valid), 0);
        end else begin
          e = sb.pop_front();
          check("flags", {29'd0, a_gt_b, a_lt_b, a_eq_b}, {29'd0, e.fl});
          check("diff", 32'(diff), 32'(e.df));
          if (e.fl[2]) exp_gt = sat(exp_gt);
          if (e.fl[1]) exp_lt = sat(exp_lt);
          if (e.fl[0]) exp_eq = sat(exp_eq);
        end
      end
      if (clr_counts) begin
        exp_gt = 0;
        exp_lt = 0;
        exp_eq = 0;
      end
      if (in_valid && in_ready) sb.push_back(model(a, b, signed_mode));
      stall_q = out_valid && !out_ready;
      held_fl = {out_valid, a_gt_b, a_lt_b, a_eq_b};
      held_df = diff;
    end
  end

  // All driving tasks start and end at posedge+1.
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic sm);
    bit ok = 0;
    a           = x;
    b           = y;
    signed_mode = sm;
    in_valid    = 1'b1;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("send_timeout", 32'(in_ready), 1);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    bit ok = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("drain_timeout", 32'(sb.size()) + 32'(out_valid), 0);
    @(posedge clk); #1;
  endtask

  task automatic pulse_clear();
    clr_counts = 1'b1;
    @(posedge clk); #1;
    clr_counts = 1'b0;
  endtask

  initial begin
    bit ok;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    a           = '0;
    b           = '0;
    signed_mode = 1'b0;
    out_ready   = 1'b1;
    clr_counts  = 1'b0;
    #2;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_flags", {29'd0, a_gt_b, a_lt_b, a_eq_b}, 0);
    check("rst_diff", 32'(diff), 0);
    check("rst_counts", {20'd0, gt_count, lt_count, eq_count}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;

    // unsigned FF vs 01, latency check
    send(8'hFF, 8'h01, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    check("lat1_out_valid", 32'(out_valid), 0);
    @(negedge clk);
    check("lat2_out_valid", 32'(out_valid), 1);
    check("t1_gt", 32'(a_gt_b), 1);
    check("t1_diff", 32'(diff), 32'hFE);
    @(posedge clk); #1;
    drain();
    check("t1_gt_count", 32'(gt_count), 1);

    // signed compares
    send(8'hFF, 8'h01, 1'b1);
    send(8'h7F, 8'h80, 1'b1);
    drain();
    check("t2_lt_count", 32'(lt_count), 1);
    check("t2_gt_count", 32'(gt_count), 2);

    // backpressure: two buffered, third blocked
    out_ready = 1'b0;
    send(8'd1, 8'd2, 1'b0);
    send(8'd2, 8'd2, 1'b0);
    a = 8'd3; b = 8'd2; signed_mode = 1'b0; in_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("bp_in_ready", 32'(in_ready), 0);
    check("bp_out_valid", 32'(out_valid), 1);
    check("bp_lt", 32'(a_lt_b), 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    ok = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("bp_accept_timeout", 32'(in_ready), 1);
    @(posedge clk); #1;
    drain();
    check("t3_lt_count", 32'(lt_count), 2);
    check("t3_eq_count", 32'(eq_count), 1);
    check("t3_gt_count", 32'(gt_count), 3);

    // saturation
    pulse_clear();
    for (int i = 0; i < 20; i++) begin
      logic [W-1:0] v;
      v = W'($urandom_range(0, 255));
      send(v, v, 1'($urandom_range(0, 1)));
    end
    drain();
    check("sat_eq_count", 32'(eq_count), 32'hF);
    check("sat_gt_count", 32'(gt_count), 0);
    check("sat_lt_count", 32'(lt_count), 0);

    // clear racing an eq handshake
    pulse_clear();
    for (int i = 0; i < 5; i++) send(8'd9, 8'd9, 1'b0);
    drain();
    check("race_pre_eq", 32'(eq_count), 5);
    out_ready = 1'b0;
    send(8'd9, 8'd9, 1'b0);
    in_valid = 1'b0;
    ok = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("race_wait_timeout", 32'(out_valid), 1);
    @(posedge clk); #1;
    out_ready  = 1'b1;
    clr_counts = 1'b1;
    @(posedge clk); #1;
    clr_counts = 1'b0;
    @(negedge clk);
    check("race_eq_count", 32'(eq_count), 0);
    @(posedge clk); #1;

    // async reset with two in flight
    for (int i = 0; i < 3; i++) send(8'd5, 8'd1, 1'b0);
    drain();
    out_ready = 1'b0;
    send(8'd1, 8'd5, 1'b0);
    send(8'd2, 8'd5, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    check("ar_pre_out_valid", 32'(out_valid), 1);
    check("ar_pre_gt_count", 32'(gt_count), 3);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("ar_out_valid", 32'(out_valid), 0);
    check("ar_flags", {29'd0, a_gt_b, a_lt_b, a_eq_b}, 0);
    check("ar_diff", 32'(diff), 0);
    check("ar_counts", {20'd0, gt_count, lt_count, eq_count}, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    rst_n     = 1'b1;
    check("ar_in_ready", 32'(in_ready), 1);
    repeat (5) begin
      @(negedge clk);
      check("ar_no_stale", 32'(out_valid), 0);
    end
    @(posedge clk); #1;

    // random traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      in_valid    = 1'($urandom_range(0, 1));
      a           = W'($urandom_range(0, 255));
      b           = ($urandom_range(0, 7) == 0) ? a : W'($urandom_range(0, 255));
      signed_mode = 1'($urandom_range(0, 1));
      out_ready   = ($urandom_range(0, 3) != 0);
      clr_counts  = ($urandom_range(0, 63) == 0);
      @(posedge clk); #1;
    end
    clr_counts = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
